axis_lrelu_out_packer: RTL and testbench
========================================

Name: axis_lrelu_out_packer

Overview:
- Sits directly downstream of the leaky-ReLU engine's output register slice.
- Each input beat carries COPIES*GROUPS slots. Each slot is UNITS words of WORD_WIDTH bits, with one keep bit per slot.
- The block serialises only the kept slots, one slot per output beat, onto a narrow AXI-Stream feeding the output DMA.
- It generates tlast from the end-of-tensor flag in tuser and counts emitted beats for software.

Parameters:
- WORD_WIDTH, 8, bits per output word.
- UNITS, 8, words per slot; output data width is UNITS*WORD_WIDTH.
- GROUPS, 2, groups per copy.
- COPIES, 2, copies per input beat; SLOTS = COPIES*GROUPS.
- COUNT_WIDTH, 32, width of the emitted-beat counter.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high together with tvalid.
- s_axis_tdata  in  SLOTS*UNITS*WORD_WIDTH  slot k occupies bits [(k+1)*UNITS*WORD_WIDTH-1 : k*UNITS*WORD_WIDTH], k = GROUPS*c+g.
- s_axis_tkeep  in  SLOTS  bit k high means slot k is valid.
- s_axis_tuser  in  2  bit1 = last beat of tensor; bit0 = reserved, ignored.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  UNITS*WORD_WIDTH  one slot.
- m_axis_tlast  out  1  final slot of tensor.
- beat_count  out  COUNT_WIDTH  output handshakes since last tlast handshake.
- err_empty_last  out  1  sticky; an end-of-tensor beat arrived with all keep bits zero.

Behaviour:
- Reset (async assert, sync release) values:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - beat_count=0, err_empty_last=0.
  - s_axis_tready=1, state=IDLE, pending mask=0.
- Reset mid-drain discards the held beat; no partial output follows.
- Storage: one held-beat register (data, pending mask[SLOTS-1:0], last flag). State is IDLE or DRAIN.
- Current slot = lowest set bit of the pending mask (priority encoder).
- m_axis_tdata = held slot[current], registered.
- m_axis_tvalid = (state==DRAIN).
- m_axis_tlast = held last flag AND pending mask has exactly one bit set.
- Output holds stable while tvalid && !tready (AXI rule).
- s_axis_tready = (state==IDLE) OR (pending mask has exactly one bit set AND m_axis_tready). This allows back-to-back beats with no bubble.
- Accepting an input beat with tkeep!=0:
  - Load data, mask=tkeep, last=tuser[1].
  - state=DRAIN; first output valid in the next cycle (latency 1).
- Accepting an input beat with tkeep==0:
  - Beat is consumed; no output; state unchanged (IDLE).
  - If tuser[1]=1, set err_empty_last, cleared only by reset.
  - Such a beat accepted in the same cycle as the final slot handshake: the block goes to IDLE.
- Output handshake (m_axis_tvalid && m_axis_tready):
  - Clear the current bit of the pending mask; the next lowest bit is presented next cycle.
  - If the mask becomes zero and no beat is accepted that cycle, go to IDLE.
  - If a beat is accepted that cycle, load it (load overrides clear).
- beat_count:
  - Increments on each output handshake, wrapping at 2^COUNT_WIDTH.
  - On a handshake with tlast=1 it is set to 0.
- Slot order within a beat is strictly ascending k. Slots are never duplicated or reordered across beats.
- m_axis_tready may toggle arbitrarily; throughput is one slot per cycle when tready is held high.
- Target size: 150–250 lines RTL.

Test Plan:
- Defaults; one beat tkeep=4'b1111, tuser=2'b10, slot k data = {8{8'h10+k}}, tready=1 -> outputs 0x1010..10, 0x1111..11, 0x1212..12, 0x1313..13 on 4 consecutive cycles starting 1 cycle after accept; tlast only on 4th; beat_count 1,2,3 then 0.
- Sparse keep 4'b1010, tuser=0, then beat keep 4'b0001 tuser=2'b10 -> slots 1,3 then slot 0 with tlast; s_axis_tready high on the cycle slot 3 handshakes (no bubble); 3 output beats total.
- Backpressure: keep=4'b0111, tready pattern 1,0,0,1,1 -> tdata/tvalid stable during the 0 cycles; s_axis_tready low until the last slot handshakes; slots 0,1,2 in order.
- Empty beats: tkeep=0 tuser=0 -> accepted, no output, err_empty_last=0; tkeep=0 tuser=2'b10 -> err_empty_last=1 and stays 1 across later traffic.
- Reset mid-drain: keep=4'b1111, assert aresetn low after 2 handshakes -> immediately m_axis_tvalid=0, beat_count=0, s_axis_tready=1; after release a new beat keep=4'b0100 emits only slot 2.
- Random: 1000 beats with random keep/tuser/tready, compared against a scoreboard; slot order, tlast placement, and beat_count after each tlast all match the model.

Source files
------------

// File: rtl/axis_lrelu_out_packer.sv
// ---------------------------------------------------------------------------
// axis_lrelu_out_packer
//
// Purpose:
//   Takes wide beats from the leaky-ReLU engine output slice and serialises
//   the kept slots, one slot per output beat in ascending slot order, onto a
//   narrow AXI-Stream for the output DMA. tlast marks the final kept slot of a
//   tensor. Output handshakes are counted for software.
//
// Ports:
//   aclk, aresetn       clock (rising edge) / asynchronous active-low reset
//   s_axis_tvalid/ready input handshake
//   s_axis_tdata        SLOTS slots of UNITS*WORD_WIDTH bits, slot k at k*SLOT_W
//   s_axis_tkeep        one keep bit per slot
//   s_axis_tuser        bit1 = end of tensor, bit0 reserved
//   m_axis_tvalid/ready output handshake
//   m_axis_tdata        one slot
//   m_axis_tlast        final slot of the tensor
//   beat_count          output handshakes since the last tlast handshake
//   err_empty_last      sticky: end-of-tensor beat with no kept slots
// ---------------------------------------------------------------------------
module axis_lrelu_out_packer #(
  parameter int WORD_WIDTH  = 8,
  parameter int UNITS       = 8,
  parameter int GROUPS      = 2,
  parameter int COPIES      = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,
  input  logic                                      s_axis_tvalid,
  output logic                                      s_axis_tready,
  input  logic [COPIES*GROUPS*UNITS*WORD_WIDTH-1:0] s_axis_tdata,
  input  logic [COPIES*GROUPS-1:0]                  s_axis_tkeep,
  input  logic [1:0]                                s_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic [UNITS*WORD_WIDTH-1:0]               m_axis_tdata,
  output logic                                      m_axis_tlast,
  output logic [COUNT_WIDTH-1:0]                    beat_count,
  output logic                                      err_empty_last
);

  localparam int SLOTS  = COPIES * GROUPS;
  localparam int SLOT_W = UNITS * WORD_WIDTH;
  localparam int DATA_W = SLOTS * SLOT_W;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  held_data_q;
  logic [SLOTS-1:0]   pend_q;
  logic               last_q;

  logic               out_fire;
  logic               in_fire;
  logic               in_load;
  logic [SLOTS-1:0]   pend_after;
  logic [DATA_W-1:0]  next_data;
  logic [SLOTS-1:0]   next_pend;
  logic               next_last;

  // Reserved tuser bit has no function in this block.
  logic unused_tuser0;
  assign unused_tuser0 = s_axis_tuser[0];

  // Priority-encoded slot select: the lowest set mask bit wins.
  function automatic logic [SLOT_W-1:0] select_slot(input logic [DATA_W-1:0] data,
                                                   input logic [SLOTS-1:0]  mask);
    logic [SLOT_W-1:0] sel;
    sel = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (mask[k]) sel = data[k*SLOT_W +: SLOT_W];
    end
    return sel;
  endfunction

  assign m_axis_tvalid = (state_q == DRAIN);

  // Input is taken when idle, or when the last pending slot is leaving this
  // cycle, so consecutive beats stream with no bubble.
  assign s_axis_tready = (state_q == IDLE) || ($onehot(pend_q) && m_axis_tready);

  // Next held-beat contents: a newly accepted non-empty beat overrides the
  // clearing of the slot that just handshook.
  always_comb begin
    out_fire   = m_axis_tvalid && m_axis_tready;
    in_fire    = s_axis_tvalid && s_axis_tready;
    in_load    = in_fire && (|s_axis_tkeep);
    pend_after = out_fire ? (pend_q & (pend_q - SLOTS'(1))) : pend_q;
    next_data  = held_data_q;
    next_pend  = pend_after;
    next_last  = last_q;
    if (in_load) begin
      next_data = s_axis_tdata;
      next_pend = s_axis_tkeep;
      next_last = s_axis_tuser[1];
    end
  end

  // Held beat, state and registered output slot/tlast. The output registers
  // are recomputed from the next mask, so they stay put under backpressure.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      held_data_q  <= '0;
      pend_q       <= '0;
      last_q       <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      held_data_q  <= next_data;
      pend_q       <= next_pend;
      last_q       <= next_last;
      state_q      <= (|next_pend) ? DRAIN : IDLE;
      m_axis_tdata <= select_slot(next_data, next_pend);
      m_axis_tlast <= next_last && $onehot(next_pend);
    end
  end

  // Handshake counter restarts after each tensor; empty end-of-tensor beats
  // raise a sticky error flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_count     <= '0;
      err_empty_last <= 1'b0;
    end else begin
      if (out_fire) begin
        beat_count <= m_axis_tlast ? '0 : beat_count + COUNT_WIDTH'(1);
      end
      if (in_fire && !(|s_axis_tkeep) && s_axis_tuser[1]) begin
        err_empty_last <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_lrelu_out_packer.sv
// ---------------------------------------------------------------------------
// tb_axis_lrelu_out_packer
//
// Directed and randomised stimulus for axis_lrelu_out_packer. A queue holds
// the slots the packer still owes downstream; every cycle the DUT outputs are
// compared against the head of that queue and against the handshake counter
// and error flag the reference keeps.
// ---------------------------------------------------------------------------
module tb_axis_lrelu_out_packer;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 64;

  logic                      aclk = 1'b0;
  logic                      aresetn;
  logic                      s_axis_tvalid;
  logic                      s_axis_tready;
  logic [SLOTS*SLOT_W-1:0]   s_axis_tdata;
  logic [SLOTS-1:0]          s_axis_tkeep;
  logic [1:0]                s_axis_tuser;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [SLOT_W-1:0]         m_axis_tdata;
  logic                      m_axis_tlast;
  logic [31:0]               beat_count;
  logic                      err_empty_last;

  typedef struct {
    logic [SLOT_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_count;
  logic        exp_err;
  int          hs_count;
  int          compared;
  int          mismatched;
  bit          rand_ready;

  axis_lrelu_out_packer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .beat_count    (beat_count),
    .err_empty_last(err_empty_last)
  );

  // 10 ns clock.
  always #5 aclk = ~aclk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Random downstream backpressure, changed just after each rising edge.
  always @(posedge aclk) begin
    if (rand_ready) begin
      #1;
      m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: owed slots in a queue, checked at the falling edge, then
  // advanced for the handshakes that will occur at the next rising edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_q.delete();
      exp_count = '0;
      exp_err   = 1'b0;
    end else begin
      logic exp_ready;
      int   top;
      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && m_axis_tready);
      check_output("tvalid", 64'(m_axis_tvalid), 64'(exp_q.size() != 0));
      check_output("s_tready", 64'(s_axis_tready), 64'(exp_ready));
      check_output("beat_count", 64'(beat_count), 64'(exp_count));
      check_output("err_empty_last", 64'(err_empty_last), 64'(exp_err));
      if (exp_q.size() != 0) begin
        check_output("tdata", m_axis_tdata, exp_q[0].data);
        check_output("tlast", 64'(m_axis_tlast), 64'(exp_q[0].last));
        if (m_axis_tready) begin
          exp_count = exp_q[0].last ? 32'd0 : exp_count + 32'd1;
          void'(exp_q.pop_front());
          hs_count++;
        end
      end
      if (s_axis_tvalid && exp_ready) begin
        top = -1;
        for (int k = 0; k < SLOTS; k++) if (s_axis_tkeep[k]) top = k;
        for (int k = 0; k < SLOTS; k++) begin
          if (s_axis_tkeep[k]) begin
            exp_t e;
            e.data = s_axis_tdata[k*SLOT_W +: SLOT_W];
            e.last = s_axis_tuser[1] && (k == top);
            exp_q.push_back(e);
          end
        end
        if (top < 0 && s_axis_tuser[1]) exp_err = 1'b1;
      end
    end
  end

  // Present one beat (called just after a rising edge) and hold it until taken.
  task automatic apply_stimulus(input logic [3:0] keep, input logic [1:0] user,
                                input logic [SLOTS*SLOT_W-1:0] data);
    bit acc;
    acc = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tkeep  = keep;
    s_axis_tuser  = user;
    s_axis_tdata  = data;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge aclk);
      if (s_axis_tready) acc = 1'b1;
    end
    check_output("accept", 64'(acc), 64'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge aclk);
    check_output("drain", 64'(exp_q.size()), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [SLOTS*SLOT_W-1:0] rand_data();
    logic [SLOTS*SLOT_W-1:0] d;
    for (int w = 0; w < SLOTS * SLOT_W / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [SLOTS*SLOT_W-1:0] d;
    int base;
    int bp [5] = '{1, 0, 0, 1, 1};
    compared      = 0;
    mismatched    = 0;
    hs_count      = 0;
    rand_ready    = 1'b0;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    #1;
    check_output("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_output("rst_tdata", m_axis_tdata, 64'd0);
    check_output("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check_output("rst_beat_count", 64'(beat_count), 64'd0);
    check_output("rst_err", 64'(err_empty_last), 64'd0);
    check_output("rst_s_tready", 64'(s_axis_tready), 64'd1);
    repeat (3) @(posedge aclk);
    #2;
    aresetn = 1'b1;

    // Full beat, end of tensor, slot k = bytes 0x10+k.
    for (int k = 0; k < SLOTS; k++)
      for (int u = 0; u < 8; u++) d[k*SLOT_W + u*8 +: 8] = 8'(8'h10 + k);
    base = hs_count;
    apply_stimulus(4'b1111, 2'b10, d);
    wait_drain();
    check_output("t1_beats", 64'(hs_count - base), 64'd4);
    check_output("t1_count_zero", 64'(beat_count), 64'd0);

    // Sparse beat followed back-to-back by a single-slot tensor end.
    base = hs_count;
    apply_stimulus(4'b1010, 2'b00, rand_data());
    apply_stimulus(4'b0001, 2'b10, rand_data());
    wait_drain();
    check_output("t2_beats", 64'(hs_count - base), 64'd3);

    // Backpressure pattern 1,0,0,1,1 from the first valid cycle.
    base = hs_count;
    apply_stimulus(4'b0111, 2'b00, rand_data());
    for (int i = 0; i < 5; i++) begin
      m_axis_tready = 1'(bp[i]);
      @(posedge aclk);
      #1;
    end
    m_axis_tready = 1'b1;
    wait_drain();
    check_output("t3_beats", 64'(hs_count - base), 64'd3);
    check_output("t3_count", 64'(beat_count), 64'd3);

    // Empty beats: plain one is harmless, end-of-tensor one sets the error.
    apply_stimulus(4'b0000, 2'b00, rand_data());
    @(negedge aclk);
    check_output("t4_err_clear", 64'(err_empty_last), 64'd0);
    @(posedge aclk);
    #1;
    apply_stimulus(4'b0000, 2'b10, rand_data());
    @(negedge aclk);
    check_output("t4_err_set", 64'(err_empty_last), 64'd1);
    @(posedge aclk);
    #1;
    apply_stimulus(4'b0011, 2'b10, rand_data());
    wait_drain();
    check_output("t4_err_sticky", 64'(err_empty_last), 64'd1);

    // Reset after two handshakes of a full beat.
    base = hs_count;
    apply_stimulus(4'b1111, 2'b00, rand_data());
    for (int i = 0; i < 50 && (hs_count - base) < 2; i++) @(negedge aclk);
    check_output("t5_two_hs", 64'(hs_count - base), 64'd2);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    check_output("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_output("t5_count", 64'(beat_count), 64'd0);
    check_output("t5_s_tready", 64'(s_axis_tready), 64'd1);
    check_output("t5_err", 64'(err_empty_last), 64'd0);
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    base = hs_count;
    apply_stimulus(4'b0100, 2'b00, rand_data());
    wait_drain();
    check_output("t5_beats", 64'(hs_count - base), 64'd1);

    // Randomised traffic against the reference model.
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge aclk);
        #1;
      end
      apply_stimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), rand_data());
    end
    rand_ready = 1'b0;
    @(posedge aclk);
    #2;
    m_axis_tready = 1'b1;
    wait_drain();
    repeat (2) @(posedge aclk);
    #1;
    check_output("final_idle", 64'(m_axis_tvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
